// File: rtl/axis_test_checker_pkg.sv
// axis_test_checker_pkg: state encoding, test-pattern field layout and last-word keep helper
package axis_test_checker_pkg;
  typedef enum logic [1:0] {S_UNLOCKED, S_DROP, S_IDLE, S_PKT} state_t;
  localparam int SEQ_MSB = 63;
  localparam int SEQ_LSB = 32;
  localparam int IDX_MSB = 31;
  localparam int IDX_LSB = 0;
  localparam int LEN_MSB = 15;
  localparam int LEN_LSB = 0;
  function automatic logic [7:0] keep_from_len(input logic [15:0] len);
    logic [2:0] r;
    r = 3'(len - 16'd1);
    return 8'hFF >> (3'd7 - r);
  endfunction
endpackage

// File: rtl/axis_test_checker_if.sv
// axis_test_checker_if: receive-side AXI-Stream bundle without tready
interface axis_test_checker_if;
  logic [63:0] tdata;
  logic [31:0] tuser;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  modport master (output tdata, tuser, tkeep, tlast, tvalid);
  modport slave  (input  tdata, tuser, tkeep, tlast, tvalid);
endinterface

// File: rtl/axis_test_checker_keep_gen.sv
// axis_test_checker_keep_gen: payload byte length to last-word tkeep
module axis_test_checker_keep_gen
  import axis_test_checker_pkg::*;
(
  input  logic [15:0] len,
  output logic [7:0]  keep
);
  assign keep = keep_from_len(len);
endmodule

// File: rtl/axis_test_checker.sv
// axis_test_checker: checks received test-pattern payloads and counts good/bad packets
module axis_test_checker
  import axis_test_checker_pkg::*;
#(
  parameter int P_MAX_LEN = 1472,
  parameter int P_CNT_W   = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  axis_test_checker_if.slave        s_axis,
  output logic                      o_lock,
  output logic                      o_pkt_done,
  output logic                      o_pkt_err,
  output logic [2:0]                o_err_flags,
  output logic [P_CNT_W-1:0]        o_good_cnt,
  output logic [P_CNT_W-1:0]        o_err_cnt,
  output logic [31:0]               o_last_seq
);
  state_t state, state_d;
  logic [15:0] len_q, len;
  logic [31:0] seq_q, seq, exp_seq, k_q, k, n;
  logic [2:0] acc_q, err, tot;
  logic [7:0] last_keep, exp_keep, mask_b;
  logic [63:0] mask;
  logic first, legal, in_range, is_last, drop, accept, finish;
  logic unused_tuser;
  assign unused_tuser = ^s_axis.tuser[31:16];
  // word 0 takes length and seq from the bus, later words use the latched copies
  assign first    = state == S_UNLOCKED || state == S_IDLE;
  assign len      = first ? s_axis.tuser[LEN_MSB:LEN_LSB] : len_q;
  assign seq      = first ? s_axis.tdata[SEQ_MSB:SEQ_LSB] : seq_q;
  assign k        = first ? 32'd0 : k_q;
  assign n        = 32'({1'b0, len} + 17'd7) >> 3;
  assign legal    = len >= 16'd8 && 32'(len) <= P_MAX_LEN;
  assign in_range = k < n;
  assign is_last  = k == n - 32'd1;
  axis_test_checker_keep_gen u_keep_gen (.len(len), .keep(last_keep));
  assign exp_keep = is_last ? last_keep : 8'hFF;
  // word 0 leaves its seq half to the sequence rule; words past N are not data-checked
  assign mask_b   = in_range ? exp_keep & (first ? 8'h0F : 8'hFF) : 8'h00;
  for (genvar i = 0; i < 8; i++) begin : g_mask
    assign mask[8*i +: 8] = {8{mask_b[i]}};
  end
  assign err[0] = |((s_axis.tdata ^ {seq, k[IDX_MSB:IDX_LSB]}) & mask);
  assign err[1] = !legal || !in_range || s_axis.tkeep != exp_keep || (s_axis.tlast && !is_last);
  assign err[2] = state == S_IDLE && seq != exp_seq;
  assign tot    = (first ? 3'b000 : acc_q) | err;
  assign drop   = state == S_DROP || (state == S_UNLOCKED && !legal);
  assign accept = s_axis.tvalid && !drop;
  assign finish = accept && s_axis.tlast;
  // next state: before lock an illegal word 0 is dropped through its tlast
  always_comb begin
    state_d = state;
    if (s_axis.tvalid) state_d = drop ? (s_axis.tlast ? S_UNLOCKED : S_DROP) : (s_axis.tlast ? S_IDLE : S_PKT);
  end
  // state register
  always_ff @(posedge i_clk) state <= i_rst ? S_UNLOCKED : state_d;
  // per-packet context: latched length/seq, word index, accumulated errors, expected next seq
  always_ff @(posedge i_clk)
    if (i_rst) begin
      len_q   <= '0;
      seq_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      exp_seq <= '0;
    end else if (accept) begin
      len_q <= len;
      seq_q <= seq;
      k_q   <= k + 32'd1;
      acc_q <= tot;
      if (first) exp_seq <= seq + 32'd1;
    end
  // packet results, sticky flags and saturating counters
  always_ff @(posedge i_clk)
    if (i_rst) begin
      o_lock      <= 1'b0;
      o_pkt_done  <= 1'b0;
      o_pkt_err   <= 1'b0;
      o_err_flags <= '0;
      o_good_cnt  <= '0;
      o_err_cnt   <= '0;
      o_last_seq  <= '0;
    end else begin
      o_pkt_done <= finish;
      if (finish) begin
        o_lock      <= 1'b1;
        o_pkt_err   <= |tot;
        o_err_flags <= o_err_flags | tot;
        o_last_seq  <= seq;
        if (|tot) o_err_cnt <= &o_err_cnt ? o_err_cnt : o_err_cnt + P_CNT_W'(1);
        else o_good_cnt <= &o_good_cnt ? o_good_cnt : o_good_cnt + P_CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_axis_test_checker.sv
// tb_axis_test_checker: randomized packet-level checks of axis_test_checker against a pattern model
module tb_axis_test_checker;
  localparam int CW = 8;
  localparam int MAX_LEN = 1472;
  localparam int SAT = (1 << CW) - 1;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic o_lock, o_pkt_done, o_pkt_err;
  logic [2:0] o_err_flags;
  logic [CW-1:0] o_good_cnt, o_err_cnt;
  logic [31:0] o_last_seq;
  axis_test_checker_if s_axis ();
  // narrow counters so saturation is reachable in a short run
  axis_test_checker #(.P_MAX_LEN(MAX_LEN), .P_CNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .s_axis(s_axis),
    .o_lock(o_lock), .o_pkt_done(o_pkt_done), .o_pkt_err(o_pkt_err), .o_err_flags(o_err_flags),
    .o_good_cnt(o_good_cnt), .o_err_cnt(o_err_cnt), .o_last_seq(o_last_seq)
  );
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;
  logic [64:0] obs_q[$];
  logic [64:0] exp_q[$];
  logic [64:0] o_r, e_r;
  always @(negedge i_clk) if (o_pkt_done === 1'b1) obs_q.push_back({o_pkt_err, o_last_seq, 32'(cyc)});
  bit m_locked;
  logic [31:0] m_exp, m_last;
  int m_good, m_err;
  logic [2:0] m_flags;
  int n_pass = 0;
  int n_chk = 0;

  task automatic do_reset(input int cycles);
    i_rst = 1'b1;
    s_axis.tvalid = 1'b0;
    repeat (cycles) @(posedge i_clk);
    #1 i_rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    m_locked = 0; m_exp = '0; m_last = '0; m_good = 0; m_err = 0; m_flags = '0;
  endtask

  // drives one packet (cw/cb = corrupted word/byte, -1 for none) and predicts its outcome
  task automatic send_pkt(input logic [31:0] seq, input int len, input int nw, input int cw, input int cb,
                          input int gap, input bit bad_keep);
    int n, nb;
    logic [7:0] lk, kp, kc;
    logic [63:0] w;
    bit legal, e_data, e_len, e_seq;
    n = (len + 7) / 8;
    nb = len - 8 * (n - 1);
    lk = (n > 0) ? 8'((1 << nb) - 1) : 8'h00;
    legal = len >= 8 && len <= MAX_LEN;
    for (int k = 0; k < nw; k++) begin
      while ($urandom_range(99) < gap) begin
        s_axis.tvalid = 1'b0;
        s_axis.tlast = 1'($urandom);
        s_axis.tdata = {$urandom, $urandom};
        @(posedge i_clk); #1;
      end
      w = {seq, 32'(k)};
      if (k == cw) w[8*cb +: 8] = w[8*cb +: 8] ^ 8'hA5;
      kp = (k == n - 1) ? lk : 8'hFF;
      if (bad_keep && k == 0) kp = kp ^ 8'h01;
      s_axis.tdata = w;
      s_axis.tkeep = kp;
      s_axis.tlast = (k == nw - 1);
      s_axis.tuser = (k == 0) ? {16'($urandom), 16'(len)} : $urandom;
      s_axis.tvalid = 1'b1;
      @(posedge i_clk); #1;
    end
    s_axis.tvalid = 1'b0;
    if (!m_locked && !legal) return;
    kc = (cw == n - 1) ? lk : 8'hFF;
    e_data = cw >= 0 && cw < nw && cw < n && kc[cb] && !(cw == 0 && cb >= 4);
    e_len = !legal || nw != n || bad_keep;
    e_seq = m_locked && seq != m_exp;
    exp_q.push_back({e_data | e_len | e_seq, seq, 32'(cyc)});
    m_flags = m_flags | {e_seq, e_len, e_data};
    if (e_data | e_len | e_seq) m_err = (m_err == SAT) ? SAT : m_err + 1;
    else m_good = (m_good == SAT) ? SAT : m_good + 1;
    m_locked = 1;
    m_exp = seq + 32'd1;
    m_last = seq;
  endtask

  task automatic test_reset;
    do_reset(3);
    n_chk++; if (o_lock !== 1'b0) $display("FAIL reset_lock: got %b, expected 0", o_lock); else n_pass++;
    n_chk++; if (o_pkt_done !== 1'b0) $display("FAIL reset_done: got %b, expected 0", o_pkt_done); else n_pass++;
    n_chk++; if (o_pkt_err !== 1'b0) $display("FAIL reset_err: got %b, expected 0", o_pkt_err); else n_pass++;
    n_chk++; if (o_err_flags !== 3'b000) $display("FAIL reset_flags: got %b, expected 000", o_err_flags); else n_pass++;
    n_chk++; if (o_good_cnt !== '0) $display("FAIL reset_good: got %0d, expected 0", o_good_cnt); else n_pass++;
    n_chk++; if (o_err_cnt !== '0) $display("FAIL reset_errcnt: got %0d, expected 0", o_err_cnt); else n_pass++;
    n_chk++; if (o_last_seq !== '0) $display("FAIL reset_seq: got %0h, expected 0", o_last_seq); else n_pass++;
  endtask

  task automatic test_basic;
    do_reset(2);
    for (int s = 0; s < 3; s++) begin
      send_pkt(32'(s), 64, 8, -1, 0, 0, 0);
      @(posedge i_clk); #1;
    end
    repeat (3) @(posedge i_clk); #1;
    n_chk++;
    if (obs_q.size() != 3) $display("FAIL basic_count: %0d pulses, expected 3", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o_r = obs_q.pop_front(); e_r = exp_q.pop_front();
      n_chk++;
      if (o_r !== e_r) $display("FAIL basic_pkt: err/seq/cycle %0b/%0h/%0d, expected %0b/%0h/%0d", o_r[64], o_r[63:32], o_r[31:0], e_r[64], e_r[63:32], e_r[31:0]);
      else n_pass++;
    end
    n_chk++; if (o_good_cnt !== CW'(3)) $display("FAIL basic_good: got %0d, expected 3", o_good_cnt); else n_pass++;
    n_chk++; if (o_lock !== 1'b1) $display("FAIL basic_lock: got %b, expected 1", o_lock); else n_pass++;
    n_chk++; if (o_last_seq !== 32'd2) $display("FAIL basic_seq: got %0h, expected 2", o_last_seq); else n_pass++;
  endtask

  task automatic test_keep_mask;
    do_reset(2);
    send_pkt(32'd0, 13, 2, 1, 5, 0, 0);
    send_pkt(32'd1, 13, 2, 1, 4, 0, 0);
    for (int i = 0; i < 12; i++) begin
      int len, w, b;
      len = $urandom_range(8, 60);
      w = $urandom_range((len + 7) / 8 - 1);
      b = (w == 0) ? $urandom_range(3) : $urandom_range(7);
      send_pkt(m_exp, len, (len + 7) / 8, w, b, 0, 0);
    end
    repeat (3) @(posedge i_clk); #1;
    n_chk++;
    if (obs_q.size() != exp_q.size()) $display("FAIL keep_count: %0d pulses, expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o_r = obs_q.pop_front(); e_r = exp_q.pop_front();
      n_chk++;
      if (o_r !== e_r) $display("FAIL keep_pkt%0d: err/seq/cycle %0b/%0h/%0d, expected %0b/%0h/%0d", i, o_r[64], o_r[63:32], o_r[31:0], e_r[64], e_r[63:32], e_r[31:0]);
      else n_pass++;
      if (i == 1) begin
        n_chk++; if (o_r[64] !== 1'b1) $display("FAIL keep_byte4: pkt_err %b, expected 1", o_r[64]); else n_pass++;
      end
    end
    n_chk++; if (o_err_flags[2:1] !== 2'b00 || o_err_flags[0] !== 1'b1) $display("FAIL keep_flags: got %b, expected 001", o_err_flags); else n_pass++;
    n_chk++; if (o_good_cnt !== CW'(m_good) || o_err_cnt !== CW'(m_err)) $display("FAIL keep_cnts: good/err %0d/%0d, expected %0d/%0d", o_good_cnt, o_err_cnt, m_good, m_err); else n_pass++;
  endtask

  task automatic test_seq;
    logic [31:0] seqs [4];
    seqs = '{32'd5, 32'd6, 32'd8, 32'd9};
    do_reset(2);
    foreach (seqs[i]) send_pkt(seqs[i], 64, 8, -1, 0, 0, 0);
    repeat (3) @(posedge i_clk); #1;
    n_chk++;
    if (obs_q.size() != 4) $display("FAIL seq_count: %0d pulses, expected 4", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o_r = obs_q.pop_front(); e_r = exp_q.pop_front();
      n_chk++;
      if (o_r !== e_r) $display("FAIL seq_pkt: err/seq/cycle %0b/%0h/%0d, expected %0b/%0h/%0d", o_r[64], o_r[63:32], o_r[31:0], e_r[64], e_r[63:32], e_r[31:0]);
      else n_pass++;
    end
    n_chk++; if (o_err_cnt !== CW'(1)) $display("FAIL seq_errcnt: got %0d, expected 1", o_err_cnt); else n_pass++;
    n_chk++; if (o_good_cnt !== CW'(3)) $display("FAIL seq_good: got %0d, expected 3", o_good_cnt); else n_pass++;
    n_chk++; if (o_err_flags !== 3'b100) $display("FAIL seq_flags: got %b, expected 100", o_err_flags); else n_pass++;
  endtask

  task automatic test_back_to_back;
    do_reset(2);
    send_pkt(32'd0, 64, 7, -1, 0, 0, 0);
    send_pkt(32'd1, 64, 8, -1, 0, 0, 0);
    send_pkt(32'd2, 4, 1, -1, 0, 0, 0);
    send_pkt(32'd3, 1500, 188, -1, 0, 0, 0);
    send_pkt(32'd4, 64, 9, -1, 0, 0, 0);
    send_pkt(32'd5, 40, 5, -1, 0, 0, 1);
    send_pkt(32'd6, 8, 1, -1, 0, 0, 0);
    repeat (3) @(posedge i_clk); #1;
    n_chk++;
    if (obs_q.size() != 7) $display("FAIL b2b_count: %0d pulses, expected 7", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o_r = obs_q.pop_front(); e_r = exp_q.pop_front();
      n_chk++;
      if (o_r !== e_r) $display("FAIL b2b_pkt: err/seq/cycle %0b/%0h/%0d, expected %0b/%0h/%0d", o_r[64], o_r[63:32], o_r[31:0], e_r[64], e_r[63:32], e_r[31:0]);
      else n_pass++;
    end
    n_chk++; if (o_good_cnt !== CW'(2) || o_err_cnt !== CW'(5)) $display("FAIL b2b_cnts: good/err %0d/%0d, expected 2/5", o_good_cnt, o_err_cnt); else n_pass++;
    n_chk++; if (o_err_flags !== 3'b010) $display("FAIL b2b_flags: got %b, expected 010", o_err_flags); else n_pass++;
  endtask

  task automatic test_gaps_reset;
    do_reset(2);
    send_pkt(32'd100, MAX_LEN, 184, -1, 0, 30, 0);
    repeat (3) @(posedge i_clk); #1;
    n_chk++;
    if (obs_q.size() != 1) $display("FAIL gap_count: %0d pulses, expected 1", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o_r = obs_q.pop_front(); e_r = exp_q.pop_front();
      n_chk++;
      if (o_r !== e_r || o_r[64] !== 1'b0) $display("FAIL gap_pkt: err/seq/cycle %0b/%0h/%0d, expected %0b/%0h/%0d", o_r[64], o_r[63:32], o_r[31:0], e_r[64], e_r[63:32], e_r[31:0]);
      else n_pass++;
    end
    for (int k = 0; k < 10; k++) begin
      s_axis.tdata = {32'd101, 32'(k)};
      s_axis.tkeep = 8'hFF;
      s_axis.tlast = 1'b0;
      s_axis.tuser = {16'd0, 16'(MAX_LEN)};
      s_axis.tvalid = 1'b1;
      @(posedge i_clk); #1;
    end
    do_reset(2);
    n_chk++; if (o_good_cnt !== '0 || o_err_cnt !== '0) $display("FAIL midrst_cnts: good/err %0d/%0d, expected 0/0", o_good_cnt, o_err_cnt); else n_pass++;
    n_chk++; if (o_lock !== 1'b0) $display("FAIL midrst_lock: got %b, expected 0", o_lock); else n_pass++;
    send_pkt(32'd50, 4, 1, -1, 0, 0, 0);
    send_pkt(32'd51, 2000, 5, -1, 0, 0, 0);
    repeat (3) @(posedge i_clk); #1;
    n_chk++; if (o_lock !== 1'b0 || obs_q.size() != 0) $display("FAIL drop: lock %b pulses %0d, expected 0 and 0", o_lock, obs_q.size()); else n_pass++;
    send_pkt(32'd7, 64, 8, -1, 0, 10, 0);
    repeat (3) @(posedge i_clk); #1;
    n_chk++; if (o_good_cnt !== CW'(1) || o_err_cnt !== '0) $display("FAIL after_rst: good/err %0d/%0d, expected 1/0", o_good_cnt, o_err_cnt); else n_pass++;
    n_chk++; if (o_lock !== 1'b1 || o_last_seq !== 32'd7) $display("FAIL after_rst_lock: lock/seq %b/%0h, expected 1/7", o_lock, o_last_seq); else n_pass++;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturate;
    do_reset(2);
    for (int s = 0; s < SAT; s++) send_pkt(32'(s), 8, 1, -1, 0, 0, 0);
    repeat (2) @(posedge i_clk); #1;
    n_chk++; if (o_good_cnt !== CW'(SAT)) $display("FAIL sat_full: got %0d, expected %0d", o_good_cnt, SAT); else n_pass++;
    send_pkt(32'(SAT), 8, 1, -1, 0, 0, 0);
    send_pkt(32'(SAT + 1), 8, 1, -1, 0, 0, 0);
    repeat (3) @(posedge i_clk); #1;
    n_chk++; if (o_good_cnt !== CW'(SAT) || o_good_cnt !== CW'(m_good)) $display("FAIL sat_hold: got %0d, expected %0d", o_good_cnt, SAT); else n_pass++;
    n_chk++;
    if (obs_q.size() != SAT + 2) $display("FAIL sat_count: %0d pulses, expected %0d", obs_q.size(), SAT + 2); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o_r = obs_q.pop_front(); e_r = exp_q.pop_front();
      n_chk++;
      if (o_r !== e_r) $display("FAIL sat_pkt: err/seq/cycle %0b/%0h/%0d, expected %0b/%0h/%0d", o_r[64], o_r[63:32], o_r[31:0], e_r[64], e_r[63:32], e_r[31:0]);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    do_reset(2);
    for (int i = 0; i < 150; i++) begin
      int len, n, nw, w, b;
      logic [31:0] seq;
      len = ($urandom_range(9) == 0) ? (($urandom_range(1) == 0) ? $urandom_range(7) : $urandom_range(MAX_LEN + 1, 2000))
          : ($urandom_range(7) == 0) ? $urandom_range(8, MAX_LEN) : $urandom_range(8, 200);
      n = (len + 7) / 8;
      nw = n;
      if ($urandom_range(7) == 0) nw = n + int'($urandom_range(4)) - 2;
      if (nw < 1) nw = 1;
      w = ($urandom_range(3) == 0) ? $urandom_range(nw - 1) : -1;
      b = (w == 0) ? $urandom_range(3) : $urandom_range(7);
      seq = (!m_locked || $urandom_range(9) == 0) ? $urandom : m_exp;
      send_pkt(seq, len, nw, w, b, ($urandom_range(1) == 0) ? 0 : 20, $urandom_range(19) == 0);
      if ($urandom_range(1) == 0) repeat ($urandom_range(3)) @(posedge i_clk);
      #0;
    end
    repeat (3) @(posedge i_clk); #1;
    n_chk++;
    if (obs_q.size() != exp_q.size()) $display("FAIL rnd_count: %0d pulses, expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o_r = obs_q.pop_front(); e_r = exp_q.pop_front();
      n_chk++;
      if (o_r !== e_r) $display("FAIL rnd_pkt: err/seq/cycle %0b/%0h/%0d, expected %0b/%0h/%0d", o_r[64], o_r[63:32], o_r[31:0], e_r[64], e_r[63:32], e_r[31:0]);
      else n_pass++;
    end
    n_chk++; if (o_good_cnt !== CW'(m_good) || o_err_cnt !== CW'(m_err)) $display("FAIL rnd_cnts: good/err %0d/%0d, expected %0d/%0d", o_good_cnt, o_err_cnt, m_good, m_err); else n_pass++;
    n_chk++; if (o_err_flags !== m_flags) $display("FAIL rnd_flags: got %b, expected %b", o_err_flags, m_flags); else n_pass++;
    n_chk++; if (o_lock !== 1'(m_locked) || o_last_seq !== m_last) $display("FAIL rnd_lock_seq: lock/seq %b/%0h, expected %b/%0h", o_lock, o_last_seq, m_locked, m_last); else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    s_axis.tdata = '0;
    s_axis.tuser = '0;
    s_axis.tkeep = '0;
    s_axis.tlast = 1'b0;
    s_axis.tvalid = 1'b0;
    test_reset();
    test_basic();
    test_keep_mask();
    test_seq();
    test_back_to_back();
    test_gaps_reset();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
